// File: rtl/rv32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rv32_mem_arbiter
//
// Single-port arbiter for one unified code/data memory. Instruction fetch and
// MEM-stage data accesses take turns on one request/acknowledge bus that has
// variable latency. Each access returns registered read data and a one-cycle
// done pulse to the requester that issued it. cpu_hold stalls the pipeline
// while any request is still waiting to be served.
//
// Arbitration:
//   - Data accesses have priority.
//   - A pending fetch is starved for at most DATA_BURST_MAX data grants in a
//     row; after that the fetch wins.
//
// Timeout: an access that sees no ack within TIMEOUT cycles is aborted. The
// requester still gets its done pulse, with the data below, and the sticky
// bus_err flag is set.
//   - fetch: if_rdata = NOP (32'h0000_0013)
//   - data:  d_rdata  = 0
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req, if_addr             fetch request (held until if_done) and address
//   if_rdata, if_done           fetched instruction, completion pulse
//   d_req, d_read               data request (held until d_done), 1 = load
//   d_addr, d_wdata             data address, store data
//   d_rdata, d_done             load data, completion pulse
//   mem_req, mem_we             memory bus request (held until ack), write enable
//   mem_addr, mem_wdata         memory bus address and write data
//   mem_rdata, mem_ack          memory read data, access-complete strobe
//   cpu_hold                    pipeline stall while any request is eligible
//   bus_err                     sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module rv32_mem_arbiter #(
    parameter int DATA_BURST_MAX = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_read,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        cpu_hold,
    output logic        bus_err
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_IF_BUSY = 2'd1;
    localparam logic [1:0]  S_D_BUSY  = 2'd2;

    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
    localparam logic [2:0]  BURST_MAX = 3'(DATA_BURST_MAX);
    // Last ack-less cycle that is still tolerated; one more without ack aborts.
    localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q,     state_d;
    logic [2:0]  burst_q,     burst_d;
    logic [7:0]  wait_q,      wait_d;
    logic        mem_req_q,   mem_req_d;
    logic        mem_we_q,    mem_we_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic [31:0] d_rdata_q,   d_rdata_d;
    logic        if_done_q,   if_done_d;
    logic        d_done_q,    d_done_d;
    logic        bus_err_q,   bus_err_d;

    logic        if_elig;
    logic        d_elig;
    logic        fetch_forced;

    // A request whose done pulse is currently visible is already served; the
    // requester has not yet had the chance to drop or renew it.
    assign if_elig      = if_req & ~if_done_q;
    assign d_elig       = d_req  & ~d_done_q;
    assign fetch_forced = if_elig & (burst_q == BURST_MAX);

    assign cpu_hold  = if_elig | d_elig;

    assign if_rdata  = if_rdata_q;
    assign if_done   = if_done_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_err   = bus_err_q;

    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        wait_d      = wait_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        bus_err_d   = bus_err_q;

        case (state_q)
            S_IDLE: begin
                if (d_elig && !fetch_forced) begin
                    state_d     = S_D_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ~d_read;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    wait_d      = 8'd0;
                    // Count only data grants that actually made a fetch wait.
                    if (if_elig) begin
                        burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + 3'd1;
                    end else begin
                        burst_d = 3'd0;
                    end
                end else if (if_elig) begin
                    state_d    = S_IF_BUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    wait_d     = 8'd0;
                    burst_d    = 3'd0;
                end
            end

            S_IF_BUSY, S_D_BUSY: begin
                // An ack in the final allowed cycle still counts as success.
                if (mem_ack) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == S_IF_BUSY) begin
                        if_rdata_d = mem_rdata;
                        if_done_d  = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                        d_done_d = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    bus_err_d = 1'b1;
                    if (state_q == S_IF_BUSY) begin
                        if_rdata_d = NOP_INSN;
                        if_done_d  = 1'b1;
                    end else begin
                        d_rdata_d = 32'd0;
                        d_done_d  = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            burst_q     <= 3'd0;
            wait_q      <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            if_rdata_q  <= NOP_INSN;
            d_rdata_q   <= 32'd0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            wait_q      <= wait_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            bus_err_q   <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
module tb_rv32_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req_drv;
    logic        gate_if;
    wire         if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_read;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        cpu_hold;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    // Starvation test: the fetch requester is masked in data-done cycles so
    // that it is eligible only when a new data grant is being decided.
    assign if_req = if_req_drv & ~(gate_if & d_done);

    rv32_mem_arbiter #(.DATA_BURST_MAX(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_read(d_read), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .cpu_hold(cpu_hold), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: acks in busy cycle (model_lat + 1) when enabled.
    bit          model_on = 0;
    bit          model_ack_en = 1;
    int          model_lat = 0;
    logic [31:0] model_rdata = 32'd0;
    int          bcnt = 0;

    always @(negedge clk) begin
        if (model_on) begin
            if (!mem_req) begin
                mem_ack = 1'b0;
                bcnt = 0;
            end else begin
                mem_ack = model_ack_en && (bcnt == model_lat);
                mem_rdata = model_rdata;
                bcnt++;
            end
        end
    end

    // Grant monitor: records each new bus request.
    bit          mon_on = 0;
    logic        req_prev = 1'b0;
    logic        g_we[$];
    logic [31:0] g_addr[$];
    logic [31:0] g_wdata[$];

    always @(negedge clk) begin
        if (mon_on && mem_req && !req_prev) begin
            g_we.push_back(mem_we);
            g_addr.push_back(mem_addr);
            g_wdata.push_back(mem_wdata);
        end
        req_prev = mem_req;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_read;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_if_done;
        logic [31:0] e_if_rdata;
        logic        e_d_done;
        logic [31:0] e_d_rdata;
        logic        e_hold;
    } vec_t;

    vec_t vecs[17];

    task automatic run_access(input bit is_d, input bit is_load, input logic [31:0] a,
                              input logic [31:0] wd, input int lat, input bit ack,
                              input logic [31:0] rdv, output int cyc);
        model_lat = lat;
        model_ack_en = ack;
        model_rdata = rdv;
        @(posedge clk); #1;
        if (is_d) begin
            d_req = 1'b1; d_read = is_load; d_addr = a; d_wdata = wd;
        end else begin
            if_req_drv = 1'b1; if_addr = a;
        end
        cyc = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if ((is_d && d_done) || (!is_d && if_done)) begin
                cyc = k;
                break;
            end
        end
        @(posedge clk); #1;
        if_req_drv = 1'b0;
        d_req = 1'b0;
    endtask

    localparam logic [31:0] P  = 32'h0050_0093;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] I2 = 32'h0000_0513;
    localparam logic [31:0] NP = 32'h0000_0013;

    initial begin
        int cyc;
        int n;
        int found;
        int hi;
        logic        xwe[7];
        logic [31:0] xaddr[7];
        logic [31:0] xwd[7];

        //          ifr ifaddr      dr rd daddr       dwdata        ack rdata         req we addr        wdata         ifd ifrdata dd drdata hold
        vecs[0]  = '{1, 32'h100,    0, 0, 32'h0,      32'h0,        0, 32'h0,        0, 0, 32'h0,      32'h0,        0, NP, 0, 32'h0, 1};
        vecs[1]  = '{1, 32'h100,    0, 0, 32'h0,      32'h0,        1, P,            1, 0, 32'h100,    32'h0,        0, NP, 0, 32'h0, 1};
        vecs[2]  = '{1, 32'h100,    0, 0, 32'h0,      32'h0,        0, 32'h0,        0, 0, 32'h0,      32'h0,        1, P,  0, 32'h0, 0};
        vecs[3]  = '{1, 32'h104,    1, 1, 32'h2000,   32'h0,        0, 32'h0,        0, 0, 32'h0,      32'h0,        0, P,  0, 32'h0, 1};
        vecs[4]  = '{1, 32'h104,    1, 1, 32'h2000,   32'h0,        0, 32'h0,        1, 0, 32'h2000,   32'h0,        0, P,  0, 32'h0, 1};
        vecs[5]  = '{1, 32'h104,    1, 1, 32'h2000,   32'h0,        0, 32'h0,        1, 0, 32'h2000,   32'h0,        0, P,  0, 32'h0, 1};
        vecs[6]  = '{1, 32'h104,    1, 1, 32'h2000,   32'h0,        1, DB,           1, 0, 32'h2000,   32'h0,        0, P,  0, 32'h0, 1};
        vecs[7]  = '{1, 32'h104,    1, 1, 32'h2000,   32'h0,        0, 32'h0,        0, 0, 32'h0,      32'h0,        0, P,  1, DB,    1};
        vecs[8]  = '{1, 32'h104,    0, 0, 32'h0,      32'h0,        0, 32'h0,        1, 0, 32'h104,    32'h0,        0, P,  0, DB,    1};
        vecs[9]  = '{1, 32'h104,    0, 0, 32'h0,      32'h0,        0, 32'h0,        1, 0, 32'h104,    32'h0,        0, P,  0, DB,    1};
        vecs[10] = '{1, 32'h104,    0, 0, 32'h0,      32'h0,        1, I2,           1, 0, 32'h104,    32'h0,        0, P,  0, DB,    1};
        vecs[11] = '{1, 32'h104,    0, 0, 32'h0,      32'h0,        0, 32'h0,        0, 0, 32'h0,      32'h0,        1, I2, 0, DB,    0};
        vecs[12] = '{0, 32'h0,      0, 0, 32'h0,      32'h0,        1, 32'hFFFFFFFF, 0, 0, 32'h0,      32'h0,        0, I2, 0, DB,    0};
        vecs[13] = '{0, 32'h0,      1, 0, 32'h3000,   32'h12345678, 0, 32'h0,        0, 0, 32'h0,      32'h0,        0, I2, 0, DB,    1};
        vecs[14] = '{0, 32'h0,      1, 0, 32'h3000,   32'h12345678, 1, 32'h0000BAD0, 1, 1, 32'h3000,   32'h12345678, 0, I2, 0, DB,    1};
        vecs[15] = '{0, 32'h0,      1, 0, 32'h3000,   32'h12345678, 0, 32'h0,        0, 0, 32'h0,      32'h0,        0, I2, 1, DB,    0};
        vecs[16] = '{0, 32'h0,      0, 0, 32'h0,      32'h0,        0, 32'h0,        0, 0, 32'h0,      32'h0,        0, I2, 0, DB,    0};

        rst_n = 1'b0; gate_if = 1'b0; if_req_drv = 1'b0; if_addr = 32'd0;
        d_req = 1'b0; d_read = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst if_rdata", if_rdata, NP);
        chk("rst d_rdata", d_rdata, 32'd0);
        chk("rst if_done", 32'(if_done), 32'd0);
        chk("rst d_done", 32'(d_done), 32'd0);
        chk("rst bus_err", 32'(bus_err), 32'd0);
        chk("rst cpu_hold", 32'(cpu_hold), 32'd0);
        rst_n = 1'b1;

        // Cycle-accurate vectors: single fetch, load+fetch, idle ack, store
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            if_req_drv = vecs[i].if_req; if_addr = vecs[i].if_addr;
            d_req = vecs[i].d_req; d_read = vecs[i].d_read;
            d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
            mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
                chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
                chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            end
            chk($sformatf("v%0d if_done", i), 32'(if_done), 32'(vecs[i].e_if_done));
            chk($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].e_if_rdata);
            chk($sformatf("v%0d d_done", i), 32'(d_done), 32'(vecs[i].e_d_done));
            chk($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].e_d_rdata);
            chk($sformatf("v%0d cpu_hold", i), 32'(cpu_hold), 32'(vecs[i].e_hold));
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        model_on = 1;

        // Ack in the last allowed cycle: normal completion
        run_access(0, 0, 32'h200, 32'h0, 7, 1, 32'h00A00113, cyc);
        chk("tmo-edge done cycle", 32'(cyc), 32'd9);
        chk("tmo-edge if_rdata", if_rdata, 32'h00A00113);
        chk("tmo-edge bus_err", 32'(bus_err), 32'd0);

        // Fetch timeout
        run_access(0, 0, 32'h204, 32'h0, 0, 0, 32'h0, cyc);
        chk("tmo fetch done cycle", 32'(cyc), 32'd9);
        chk("tmo fetch if_rdata", if_rdata, NP);
        chk("tmo fetch bus_err", 32'(bus_err), 32'd1);

        // Load timeout
        run_access(1, 1, 32'h2100, 32'h0, 0, 0, 32'h0, cyc);
        chk("tmo load done cycle", 32'(cyc), 32'd9);
        chk("tmo load d_rdata", d_rdata, 32'd0);

        // Good access after error: bus_err stays set
        run_access(0, 0, 32'h208, 32'h0, 0, 1, 32'h11111111, cyc);
        chk("post-err done cycle", 32'(cyc), 32'd2);
        chk("post-err if_rdata", if_rdata, 32'h11111111);
        chk("post-err bus_err", 32'(bus_err), 32'd1);

        // Starvation guard: held fetch plus six back-to-back stores
        model_lat = 0; model_ack_en = 1; model_rdata = 32'h00000033;
        gate_if = 1'b1;
        mon_on = 1;
        @(posedge clk); #1;
        if_req_drv = 1'b1; if_addr = 32'h400;
        d_req = 1'b1; d_read = 1'b0; d_addr = 32'h5000; d_wdata = 32'hC0DE0000;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            @(negedge clk);
            while (!d_done && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("burst store%0d d_done", i), 32'(d_done), 32'd1);
            @(posedge clk); #1;
            if (i < 5) begin
                d_addr = 32'h5000 + 32'(4 * (i + 1));
                d_wdata = 32'hC0DE0000 + 32'(i + 1);
            end else begin
                d_req = 1'b0;
            end
        end
        n = 0;
        @(negedge clk);
        while (!if_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("burst final if_done", 32'(if_done), 32'd1);
        @(posedge clk); #1;
        if_req_drv = 1'b0; gate_if = 1'b0; mon_on = 0;

        xwe[0] = 1; xaddr[0] = 32'h5000; xwd[0] = 32'hC0DE0000;
        xwe[1] = 1; xaddr[1] = 32'h5004; xwd[1] = 32'hC0DE0001;
        xwe[2] = 1; xaddr[2] = 32'h5008; xwd[2] = 32'hC0DE0002;
        xwe[3] = 1; xaddr[3] = 32'h500C; xwd[3] = 32'hC0DE0003;
        xwe[4] = 0; xaddr[4] = 32'h0400; xwd[4] = 32'h0;
        xwe[5] = 1; xaddr[5] = 32'h5010; xwd[5] = 32'hC0DE0004;
        xwe[6] = 1; xaddr[6] = 32'h5014; xwd[6] = 32'hC0DE0005;
        chk("burst grant count", 32'(g_we.size()), 32'd8);
        if (g_we.size() >= 7) begin
            for (int j = 0; j < 7; j++) begin
                chk($sformatf("grant%0d we", j), 32'(g_we[j]), 32'(xwe[j]));
                chk($sformatf("grant%0d addr", j), g_addr[j], xaddr[j]);
                if (xwe[j]) chk($sformatf("grant%0d wdata", j), g_wdata[j], xwd[j]);
            end
        end

        // Request dropped one cycle after grant; ack three cycles later
        model_lat = 3; model_ack_en = 1; model_rdata = 32'h0BADF00D;
        @(posedge clk); #1;
        d_req = 1'b1; d_read = 1'b1; d_addr = 32'h6000; d_wdata = 32'h0;
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        chk("drop mem_req", 32'(mem_req), 32'd1);
        chk("drop cpu_hold", 32'(cpu_hold), 32'd0);
        found = 1;
        while (!d_done && found < 20) begin
            @(negedge clk);
            found++;
        end
        chk("drop done cycle", 32'(found), 32'd5);
        chk("drop d_rdata", d_rdata, 32'h0BADF00D);
        hi = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (mem_req) hi++;
        end
        chk("drop no regrant", 32'(hi), 32'd0);

        // Asynchronous reset while in D_BUSY
        model_ack_en = 0;
        @(posedge clk); #1;
        d_req = 1'b1; d_read = 1'b0; d_addr = 32'h7000; d_wdata = 32'h77;
        repeat (3) @(posedge clk);
        #2;
        chk("pre-rst mem_req", 32'(mem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst mem_req", 32'(mem_req), 32'd0);
        chk("async rst mem_we", 32'(mem_we), 32'd0);
        chk("async rst mem_addr", mem_addr, 32'd0);
        chk("async rst mem_wdata", mem_wdata, 32'd0);
        chk("async rst if_rdata", if_rdata, NP);
        chk("async rst d_rdata", d_rdata, 32'd0);
        chk("async rst d_done", 32'(d_done), 32'd0);
        chk("async rst bus_err", 32'(bus_err), 32'd0);
        d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_access(0, 0, 32'h300, 32'h0, 0, 1, 32'h00100073, cyc);
        chk("post-rst done cycle", 32'(cyc), 32'd2);
        chk("post-rst if_rdata", if_rdata, 32'h00100073);
        chk("post-rst bus_err", 32'(bus_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
